// File: rtl/ray_scanner_if.sv
// rtl/ray_scanner_if.sv - request/result bundle between a scan requester and ray_scanner
interface ray_scanner_if #(
    parameter int BOARD_N = 8,
    parameter int SQ_W    = 4
);
    localparam int IDX_W = $clog2(BOARD_N * BOARD_N);
    localparam int D_W   = $clog2(BOARD_N);

    logic                            start;
    logic                            ready;
    logic [BOARD_N*BOARD_N*SQ_W-1:0] bigBoard;
    logic [IDX_W-1:0]                currentPosition;
    logic [2:0]                      direction;
    logic [D_W-1:0]                  max_steps;
    logic                            done;
    logic                            hit;
    logic [IDX_W-1:0]                nearestPosition;
    logic [SQ_W-1:0]                 nearestPiece;
    logic [D_W-1:0]                  hit_dist;

    modport master (
        output start, bigBoard, currentPosition, direction, max_steps,
        input  ready, done, hit, nearestPosition, nearestPiece, hit_dist
    );

    modport slave (
        input  start, bigBoard, currentPosition, direction, max_steps,
        output ready, done, hit, nearestPosition, nearestPiece, hit_dist
    );
endinterface

// File: rtl/ray_scanner.sv
// rtl/ray_scanner.sv - multi-cycle eight-direction ray walk reporting the first occupied square
module ray_scanner #(
    parameter int BOARD_N = 8,
    parameter int SQ_W    = 4
) (
    input  logic          clk,
    input  logic          reset,
    ray_scanner_if.slave  bus
);
    localparam int IDX_W = $clog2(BOARD_N * BOARD_N);
    localparam int D_W   = $clog2(BOARD_N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Coordinates carry two spare bits so -1 and BOARD_N are both visible as off-board.
    localparam logic [D_W+1:0] D_ZERO  = '0;
    localparam logic [D_W+1:0] D_PLUS  = {{(D_W+1){1'b0}}, 1'b1};
    localparam logic [D_W+1:0] D_MINUS = '1;

    logic [1:0]                      state;
    logic [BOARD_N*BOARD_N*SQ_W-1:0] board_q;
    logic [D_W+1:0]                  rank_q, file_q;
    logic [D_W+1:0]                  dr_q, df_q;
    logic [D_W-1:0]                  max_q;
    logic [D_W:0]                    step_q;

    logic                            done_q, hit_q;
    logic [IDX_W-1:0]                pos_q;
    logic [SQ_W-1:0]                 piece_q;
    logic [D_W-1:0]                  dist_q;

    logic [D_W+1:0]                  dr_in, df_in;
    logic [D_W+1:0]                  cand_rank, cand_file;
    logic [IDX_W-1:0]                cand_idx;
    logic [SQ_W-1:0]                 cand_sq;
    logic                            off_board, over_limit;

    always_comb begin
        dr_in = D_ZERO;
        df_in = D_ZERO;
        case (bus.direction)
            3'b000: dr_in = D_MINUS;
            3'b001: df_in = D_MINUS;
            3'b010: df_in = D_PLUS;
            3'b011: dr_in = D_PLUS;
            3'b100: begin dr_in = D_MINUS; df_in = D_MINUS; end
            3'b101: begin dr_in = D_MINUS; df_in = D_PLUS;  end
            3'b110: begin dr_in = D_PLUS;  df_in = D_MINUS; end
            3'b111: begin dr_in = D_PLUS;  df_in = D_PLUS;  end
        endcase
    end

    // rank_q/file_q always hold the last legal square, so a miss reports them directly.
    assign cand_rank  = rank_q + dr_q;
    assign cand_file  = file_q + df_q;
    assign off_board  = (|cand_rank[D_W+1:D_W]) | (|cand_file[D_W+1:D_W]);
    assign over_limit = (max_q != '0) && (step_q > {1'b0, max_q});
    assign cand_idx   = {cand_file[D_W-1:0], cand_rank[D_W-1:0]};
    assign cand_sq    = board_q[cand_idx*SQ_W +: SQ_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            pos_q   <= '0;
            piece_q <= '0;
            dist_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        board_q <= bus.bigBoard;
                        rank_q  <= {2'b00, bus.currentPosition[D_W-1:0]};
                        file_q  <= {2'b00, bus.currentPosition[IDX_W-1:D_W]};
                        dr_q    <= dr_in;
                        df_q    <= df_in;
                        max_q   <= bus.max_steps;
                        step_q  <= {{D_W{1'b0}}, 1'b1};
                        state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (off_board || over_limit) begin
                        hit_q   <= 1'b0;
                        piece_q <= '0;
                        dist_q  <= step_q[D_W-1:0] - 1'b1;
                        pos_q   <= {file_q[D_W-1:0], rank_q[D_W-1:0]};
                        done_q  <= 1'b1;
                        state   <= S_DONE;
                    end else if (cand_sq[SQ_W-2:0] != '0) begin
                        hit_q   <= 1'b1;
                        piece_q <= cand_sq;
                        dist_q  <= step_q[D_W-1:0];
                        pos_q   <= cand_idx;
                        done_q  <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        rank_q  <= cand_rank;
                        file_q  <= cand_file;
                        step_q  <= step_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready           = (state == S_IDLE);
    assign bus.done            = done_q;
    assign bus.hit             = hit_q;
    assign bus.nearestPosition = pos_q;
    assign bus.nearestPiece    = piece_q;
    assign bus.hit_dist        = dist_q;
endmodule

// File: tb/tb_ray_scanner.sv
// tb/tb_ray_scanner.sv - directed bench for ray_scanner on 8x8 and 4x4 boards
module tb_ray_scanner;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ray_scanner_if #(.BOARD_N(8), .SQ_W(4)) b8 ();
    ray_scanner_if #(.BOARD_N(4), .SQ_W(4)) b4 ();

    ray_scanner #(.BOARD_N(8), .SQ_W(4)) dut8 (.clk(clk), .reset(rst), .bus(b8));
    ray_scanner #(.BOARD_N(4), .SQ_W(4)) dut4 (.clk(clk), .reset(rst), .bus(b4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run8(input string tag, input logic [255:0] brd, input int org, input int dir,
                        input int ms, input int e_hit, input int e_pos, input int e_pc,
                        input int e_dist, input int e_lat);
        int lat;
        bit seen;
        logic [5:0] o6;
        logic [2:0] d3;
        logic [2:0] m3;
        o6 = org[5:0];
        d3 = dir[2:0];
        m3 = ms[2:0];
        b8.bigBoard = brd;
        b8.currentPosition = o6;
        b8.direction = d3;
        b8.max_steps = m3;
        b8.start = 1'b1;
        @(posedge clk); #1;
        b8.start = 1'b0;
        b8.bigBoard = {64{4'hF}};
        b8.currentPosition = ~o6;
        b8.direction = ~d3;
        b8.max_steps = 3'd1;
        chk({tag, ".busy"}, b8.ready, 0);
        lat = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (b8.done) seen = 1;
        end
        chk({tag, ".lat"}, lat, e_lat);
        chk({tag, ".hit"}, b8.hit, e_hit);
        chk({tag, ".pos"}, b8.nearestPosition, e_pos);
        chk({tag, ".piece"}, b8.nearestPiece, e_pc);
        chk({tag, ".dist"}, b8.hit_dist, e_dist);
        @(posedge clk); #1;
        chk({tag, ".done_off"}, b8.done, 0);
        chk({tag, ".ready_back"}, b8.ready, 1);
        chk({tag, ".hold"}, b8.nearestPosition, e_pos);
    endtask

    task automatic run4(input string tag, input logic [63:0] brd, input int org, input int dir,
                        input int e_hit, input int e_pos, input int e_pc, input int e_dist,
                        input int e_lat);
        int lat;
        bit seen;
        logic [3:0] o4;
        logic [2:0] d3;
        o4 = org[3:0];
        d3 = dir[2:0];
        b4.bigBoard = brd;
        b4.currentPosition = o4;
        b4.direction = d3;
        b4.max_steps = 2'd0;
        b4.start = 1'b1;
        @(posedge clk); #1;
        b4.start = 1'b0;
        b4.bigBoard = {16{4'hF}};
        lat = 0;
        seen = 0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (b4.done) seen = 1;
        end
        chk({tag, ".lat"}, lat, e_lat);
        chk({tag, ".hit"}, b4.hit, e_hit);
        chk({tag, ".pos"}, b4.nearestPosition, e_pos);
        chk({tag, ".piece"}, b4.nearestPiece, e_pc);
        chk({tag, ".dist"}, b4.hit_dist, e_dist);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [255:0] brd;
        logic [63:0]  brd4;
        int ndone;

        rst = 1'b1;
        b8.start = 1'b0; b8.bigBoard = '0; b8.currentPosition = '0; b8.direction = '0; b8.max_steps = '0;
        b4.start = 1'b0; b4.bigBoard = '0; b4.currentPosition = '0; b4.direction = '0; b4.max_steps = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst.ready", b8.ready, 1);
        chk("rst.done", b8.done, 0);
        chk("rst.hit", b8.hit, 0);
        chk("rst.pos", b8.nearestPosition, 0);
        chk("rst.piece", b8.nearestPiece, 0);
        chk("rst.dist", b8.hit_dist, 0);

        brd = '0; brd[25*4 +: 4] = 4'hD;
        run8("up_hit", brd, 27, 0, 0, 1, 25, 4'hD, 2, 2);

        brd = '0;
        run8("dr_miss", brd, 27, 7, 0, 0, 63, 0, 4, 5);

        brd = '0; brd[27*4 +: 4] = 4'h1; brd[26*4 +: 4] = 4'h9; brd[25*4 +: 4] = 4'h3;
        run8("lim_hit", brd, 27, 0, 1, 1, 26, 4'h9, 1, 1);
        brd[26*4 +: 4] = 4'h0;
        run8("lim_miss", brd, 27, 0, 1, 0, 26, 0, 1, 2);

        brd = {64{4'h2}};
        run8("edge_up0", brd, 0, 0, 0, 0, 0, 0, 0, 1);
        run8("edge_rt63", brd, 63, 2, 0, 0, 63, 0, 0, 1);

        // colour bit alone does not make a square occupied
        brd = '0; brd[19*4 +: 4] = 4'h8; brd[11*4 +: 4] = 4'hA;
        run8("left_colour", brd, 27, 1, 0, 1, 11, 4'hA, 2, 2);

        brd = '0;
        run8("ur_miss", brd, 27, 5, 0, 0, 48, 0, 3, 4);

        brd = '0; brd[35*4 +: 4] = 4'h4;
        run8("rt_lim3", brd, 3, 2, 3, 0, 27, 0, 3, 4);

        brd = '0;
        run8("ul_worst", brd, 63, 4, 0, 0, 0, 0, 7, 8);

        brd = '0; brd[31*4 +: 4] = 4'hE;
        run8("down_far", brd, 24, 3, 0, 1, 31, 4'hE, 7, 7);

        // start pulses while busy must not spawn a second scan
        b8.bigBoard = '0; b8.currentPosition = 6'd27; b8.direction = 3'd7; b8.max_steps = '0;
        b8.start = 1'b1;
        @(posedge clk); #1;
        b8.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            b8.start = (i >= 1 && i <= 3);
            @(posedge clk); #1;
            if (b8.done) ndone++;
        end
        b8.start = 1'b0;
        chk("busy.ndone", ndone, 1);
        chk("busy.ready", b8.ready, 1);

        brd = '0; brd[25*4 +: 4] = 4'hD;
        run8("pre_rst", brd, 27, 0, 0, 1, 25, 4'hD, 2, 2);

        b8.bigBoard = '0; b8.currentPosition = 6'd27; b8.direction = 3'd7; b8.max_steps = '0;
        b8.start = 1'b1;
        @(posedge clk); #1;
        b8.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (b8.done) ndone++;
            @(posedge clk); #1;
        end
        chk("abort.ndone", ndone, 0);
        chk("abort.ready", b8.ready, 1);
        chk("abort.hit", b8.hit, 0);
        chk("abort.pos", b8.nearestPosition, 0);
        chk("abort.piece", b8.nearestPiece, 0);
        chk("abort.dist", b8.hit_dist, 0);

        brd = '0; brd[25*4 +: 4] = 4'hD;
        run8("post_rst", brd, 27, 0, 0, 1, 25, 4'hD, 2, 2);

        brd4 = '0; brd4[2*4 +: 4] = 4'h5;
        run4("n4_dl", brd4, 5, 6, 1, 2, 4'h5, 1, 1);
        brd4 = {16{4'h3}};
        run4("n4_rt", brd4, 12, 2, 0, 12, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
